pdp8l_tc08_brk: RTL and testbench

Three-cycle data-break sequencer for the PDP-8/L TC08 DECtape path. On an ARM command it transfers one 12-bit word between the ARM and PDP-8/L memory. It does this in TC08 order: increment the word count at 7754, increment the current address at 7755, then access the data word at {field, CA}. It sits between the ARM register bus and the shared memory break port, alongside the TC08 IOP interface, which supplies the DMA field bits.

---
 rtl/pdp8l_tc08_brk_pkg.sv | 44 ++++
 rtl/pdp8l_tc08_brk.sv | 198 +++++++++++++++++++
 tb/tb_pdp8l_tc08_brk.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdp8l_tc08_brk_pkg.sv
// Shared constants and types for the PDP-8/L TC08 data-break sequencer.
// Addresses are octal, as in the TC08 documentation.
package pdp8l_tc08_brk_pkg;

  localparam logic [11:0] WC_ADDR = 12'o7754;
  localparam logic [11:0] CA_ADDR = 12'o7755;

  localparam logic [1:0] REG_ID  = 2'd0;
  localparam logic [1:0] REG_CSR = 2'd1;
  localparam logic [1:0] REG_PTR = 2'd2;
  localparam logic [1:0] REG_RSV = 2'd3;

  localparam logic [31:0] TB_ID = 32'h5442_0001;

  typedef enum logic [2:0] {
    IDLE,
    WCRD,
    WCWR,
    CARD,
    CAWR,
    DATA,
    GAP
  } state_t;

  function automatic logic acc_wr(state_t s, logic dir);
    return (s == WCWR) || (s == CAWR) ||
           ((s == DATA) && dir);
  endfunction

  // WC/CA always live in field 0; only the data word uses the latched field.
  function automatic logic [14:0] acc_addr(
    state_t      s,
    logic [2:0]  fld,
    logic [11:0] ca
  );
    if (s == DATA)
      return {fld, ca};
    else if ((s == CARD) || (s == CAWR))
      return {3'b000, CA_ADDR};
    else
      return {3'b000, WC_ADDR};
  endfunction

endpackage

// File: rtl/pdp8l_tc08_brk.sv
// TC08 three-cycle data break: WC increment, CA increment, data access.
// ARM register bus on one side, PDP-8/L memory break port on the other.
module pdp8l_tc08_brk
  import pdp8l_tc08_brk_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        BINIT,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [2:0]  field,
  output logic        brkrq,
  output logic        brkwrite,
  output logic [14:0] brkaddr,
  output logic [11:0] brkwdata,
  input  logic        brkack,
  input  logic [11:0] brkrdata
);

  state_t      state_q, state_d;
  state_t      nxt_q, nxt_d;
  logic        brkrq_q, brkrq_d;
  logic        brkwr_q, brkwr_d;
  logic [14:0] brkad_q, brkad_d;
  logic [11:0] brkwd_q, brkwd_d;
  logic        busy_q, busy_d;
  logic        dir_q, dir_d;
  logic        wcovf_q, wcovf_d;
  logic        error_q, error_d;
  logic [11:0] data_q, data_d;
  logic [11:0] wc_q, wc_d;
  logic [11:0] ca_q, ca_d;
  logic [2:0]  fld_q, fld_d;

  logic        csr_wr;
  logic        start;
  logic        clr;
  logic [11:0] rd_inc;
  logic        unused_wdata;

  assign csr_wr = armwrite && (armwaddr == REG_CSR);
  assign start  = csr_wr && armwdata[31];
  assign clr    = csr_wr && !armwdata[31];
  assign rd_inc = brkrdata + 12'd1;

  assign unused_wdata = ^armwdata[29:12];

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      nxt_q   <= IDLE;
      brkrq_q <= 1'b0;
      brkwr_q <= 1'b0;
      brkad_q <= '0;
      brkwd_q <= '0;
      busy_q  <= 1'b0;
      dir_q   <= 1'b0;
      wcovf_q <= 1'b0;
      error_q <= 1'b0;
      data_q  <= '0;
      wc_q    <= '0;
      ca_q    <= '0;
      fld_q   <= '0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      brkrq_q <= brkrq_d;
      brkwr_q <= brkwr_d;
      brkad_q <= brkad_d;
      brkwd_q <= brkwd_d;
      busy_q  <= busy_d;
      dir_q   <= dir_d;
      wcovf_q <= wcovf_d;
      error_q <= error_d;
      data_q  <= data_d;
      wc_q    <= wc_d;
      ca_q    <= ca_d;
      fld_q   <= fld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    brkrq_d = brkrq_q;
    brkwr_d = brkwr_q;
    brkad_d = brkad_q;
    brkwd_d = brkwd_q;
    busy_d  = busy_q;
    dir_d   = dir_q;
    wcovf_d = wcovf_q;
    error_d = error_q;
    data_d  = data_q;
    wc_d    = wc_q;
    ca_d    = ca_q;
    fld_d   = fld_q;

    if (clr) begin
      wcovf_d = 1'b0;
      error_d = 1'b0;
    end
    if (start && busy_q)
      error_d = 1'b1;

    if (BINIT) begin
      state_d = IDLE;
      nxt_d   = IDLE;
      brkrq_d = 1'b0;
      brkwr_d = 1'b0;
      brkad_d = '0;
      brkwd_d = '0;
      busy_d  = 1'b0;
      dir_d   = 1'b0;
      wcovf_d = 1'b0;
      error_d = 1'b0;
      data_d  = '0;
      wc_d    = '0;
      ca_d    = '0;
      fld_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dir_d   = armwdata[30];
            data_d  = armwdata[11:0];
            fld_d   = field;
            busy_d  = 1'b1;
            wcovf_d = 1'b0;
            error_d = 1'b0;
            state_d = WCRD;
            brkrq_d = 1'b1;
            brkwr_d = 1'b0;
            brkad_d = {3'b000, WC_ADDR};
          end
        end
        GAP: begin
          state_d = nxt_q;
          if (nxt_q == IDLE) begin
            busy_d = 1'b0;
          end else begin
            brkrq_d = 1'b1;
            brkwr_d = acc_wr(nxt_q, dir_q);
            brkad_d = acc_addr(nxt_q, fld_q, ca_q);
            if (nxt_q == WCWR)
              brkwd_d = wc_q;
            else if (nxt_q == CAWR)
              brkwd_d = ca_q;
            else
              brkwd_d = data_q;
          end
        end
        default: begin
          if (brkack) begin
            brkrq_d = 1'b0;
            state_d = GAP;
            unique case (state_q)
              WCRD: begin
                wc_d    = rd_inc;
                wcovf_d = (rd_inc == 12'd0);
                nxt_d   = WCWR;
              end
              WCWR: nxt_d = CARD;
              CARD: begin
                ca_d  = rd_inc;
                nxt_d = CAWR;
              end
              CAWR: nxt_d = DATA;
              default: begin
                if (!dir_q)
                  data_d = brkrdata;
                nxt_d = IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    unique case (armraddr)
      REG_ID:  armrdata = TB_ID;
      REG_CSR: armrdata = {busy_q, dir_q, wcovf_q, error_q,
                           16'b0, data_q};
      REG_PTR: armrdata = {4'b0, ca_q, 4'b0, wc_q};
      default: armrdata = 32'b0;
    endcase
  end

  assign brkrq    = brkrq_q;
  assign brkwrite = brkwr_q;
  assign brkaddr  = brkad_q;
  assign brkwdata = brkwd_q;

endmodule

// File: tb/tb_pdp8l_tc08_brk.sv
// Randomized scoreboard bench for the TC08 data-break sequencer.
// A memory responder with queued ack delays checks each break access.
module tb_pdp8l_tc08_brk;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        BINIT = 1'b0;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd1;
  logic [1:0]  armwaddr = 2'd0;
  logic [31:0] armwdata = '0;
  logic [31:0] armrdata;
  logic [2:0]  field = '0;
  logic        brkrq;
  logic        brkwrite;
  logic [14:0] brkaddr;
  logic [11:0] brkwdata;
  logic        brkack = 1'b0;
  logic [11:0] brkrdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit abort_ok = 1'b0;

  logic [11:0] mem [32768];

  typedef struct packed {
    logic        w;
    logic [14:0] a;
    logic [11:0] d;
  } acc_t;

  acc_t exp_q[$];
  int   dly_q[$];

  logic [11:0] m_wc, m_ca, m_data;
  logic [2:0]  m_fld;
  bit          m_ovf, m_dir, m_err;

  pdp8l_tc08_brk dut (
    .CLOCK(CLOCK), .RESET(RESET), .BINIT(BINIT),
    .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata),
    .armrdata(armrdata), .field(field),
    .brkrq(brkrq), .brkwrite(brkwrite),
    .brkaddr(brkaddr), .brkwdata(brkwdata),
    .brkack(brkack), .brkrdata(brkrdata)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder and access monitor.
  initial begin : bus
    bit   waiting;
    bit   acked;
    int   cnt;
    acc_t snap;
    acc_t e;
    waiting = 0;
    acked = 0;
    cnt = 0;
    forever begin
      @(negedge CLOCK);
      if (acked) begin
        chk("gap_brkrq", 32'(brkrq), 32'd0);
        acked = 0;
      end
      brkack = 1'b0;
      if (brkrq === 1'b1) begin
        if (!waiting) begin
          waiting = 1;
          snap = {brkwrite, brkaddr, brkwdata};
          cnt = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_access: addr %o", brkaddr);
          end else begin
            e = exp_q.pop_front();
            chk("acc_addr", {16'd0, brkwrite, brkaddr},
                {16'd0, e.w, e.a});
            if (e.w)
              chk("acc_wdata", 32'(brkwdata), 32'(e.d));
          end
        end else begin
          chk("acc_stable", 32'({brkwrite, brkaddr, brkwdata}),
              32'(snap));
        end
        if (cnt == 0) begin
          brkack = 1'b1;
          acked = 1;
          waiting = 0;
          if (brkwrite) begin
            mem[brkaddr] = brkwdata;
            brkrdata = 12'($urandom);
          end else begin
            brkrdata = mem[brkaddr];
          end
        end else begin
          cnt--;
        end
      end else begin
        if (waiting && !abort_ok) begin
          checks++;
          failures++;
          $display("FAIL brkrq_dropped: addr %o", brkaddr);
        end
        waiting = 0;
        if ($urandom_range(3) == 0) begin
          brkack = 1'b1;
          brkrdata = 12'($urandom);
        end
      end
    end
  end

  task automatic rd(logic [1:0] a, output logic [31:0] r);
    armraddr = a;
    #1;
    r = armrdata;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    @(negedge CLOCK);
    armwaddr = a;
    armwdata = d;
    armwrite = 1'b1;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  // Reference: the five TC08 accesses and resulting registers.
  task automatic plan(bit dir, logic [11:0] d, logic [2:0] f,
                      int dmin, int dmax, output int tot);
    logic [14:0] da;
    int x;
    m_wc  = mem[15'o07754] + 12'd1;
    m_ca  = mem[15'o07755] + 12'd1;
    m_fld = f;
    da    = {f, m_ca};
    m_dir = dir;
    m_ovf = (m_wc == 12'd0);
    m_err = 0;
    m_data = dir ? d : mem[da];
    exp_q.push_back(acc_t'{1'b0, 15'o07754, 12'd0});
    exp_q.push_back(acc_t'{1'b1, 15'o07754, m_wc});
    exp_q.push_back(acc_t'{1'b0, 15'o07755, 12'd0});
    exp_q.push_back(acc_t'{1'b1, 15'o07755, m_ca});
    exp_q.push_back(acc_t'{dir, da, d});
    tot = 1;
    for (int i = 0; i < 5; i++) begin
      x = $urandom_range(dmax, dmin);
      dly_q.push_back(x);
      tot += x + 2;
    end
  endtask

  task automatic start_x(bit dir, logic [11:0] d, logic [2:0] f,
                         int dmin, int dmax,
                         output int c0, output int tot);
    plan(dir, d, f, dmin, dmax, tot);
    @(negedge CLOCK);
    field = f;
    armwaddr = 2'd1;
    armwdata = {1'b1, dir, 18'b0, d};
    armwrite = 1'b1;
    c0 = cyc;
    @(negedge CLOCK);
    armwrite = 1'b0;
    field = 3'($urandom);
    chk("rq_at_n1", 32'(brkrq), 32'd1);
  endtask

  task automatic finish_x(int exp_c);
    logic [31:0] r;
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge CLOCK);
      rd(2'd1, r);
      if (!r[31]) break;
    end
    if (k == 2000) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: busy still %b", r[31]);
    end else begin
      chk("done_cycle", 32'(cyc), 32'(exp_c));
    end
    rd(2'd1, r);
    chk("reg1", r, {1'b0, m_dir, m_ovf, m_err, 16'b0, m_data});
    rd(2'd2, r);
    chk("reg2", r, {4'b0, m_ca, 4'b0, m_wc});
    chk("mem_wc", 32'(mem[15'o07754]), 32'(m_wc));
    chk("mem_ca", 32'(mem[15'o07755]), 32'(m_ca));
    if (m_dir)
      chk("mem_data", 32'(mem[{m_fld, m_ca}]), 32'(m_data));
  endtask

  task automatic xfer(bit dir, logic [11:0] d, logic [2:0] f,
                      int dmin, int dmax);
    int c0, tot;
    start_x(dir, d, f, dmin, dmax, c0, tot);
    finish_x(c0 + tot);
  endtask

  task automatic chk_reset_state(string tag);
    logic [31:0] r;
    chk({tag, "_brkrq"}, 32'(brkrq), 32'd0);
    chk({tag, "_brkout"}, 32'({brkwrite, brkaddr, brkwdata}), 32'd0);
    rd(2'd1, r);
    chk({tag, "_reg1"}, r, 32'd0);
    rd(2'd2, r);
    chk({tag, "_reg2"}, r, 32'd0);
  endtask

  task automatic flush();
    exp_q.delete();
    dly_q.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] r;
    int c0, tot, k;
    for (int i = 0; i < 32768; i++) mem[i] = 12'($urandom);

    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    rd(2'd0, r);
    chk("reg0_id", r, 32'h5442_0001);
    rd(2'd3, r);
    chk("reg3", r, 32'd0);
    chk_reset_state("rst");

    mem[15'o07754] = 12'o7776;
    mem[15'o07755] = 12'o0177;
    xfer(1'b1, 12'o1234, 3'd3, 0, 0);
    chk("t1_data_word", 32'(mem[15'o30200]), 32'o1234);

    mem[15'o07754] = 12'o7777;
    mem[15'o07755] = 12'o7777;
    mem[15'o00000] = 12'o4321;
    xfer(1'b0, 12'o0000, 3'd0, 0, 0);
    chk("t2_wcovf", 32'(m_ovf), 32'd1);

    mem[15'o07755] = 12'o0456;
    xfer(1'b1, 12'o7070, 3'd6, 4, 4);

    start_x(1'b0, 12'o0, 3'd4, 3, 3, c0, tot);
    repeat (4) @(negedge CLOCK);
    wr(2'd1, 32'h8000_0777);
    m_err = 1;
    finish_x(c0 + tot);
    wr(2'd1, 32'h0000_0000);
    m_err = 0;
    m_ovf = 0;
    rd(2'd1, r);
    chk("err_cleared", r, {1'b0, m_dir, 2'b00, 16'b0, m_data});

    start_x(1'b1, 12'o5555, 3'd2, 8, 8, c0, tot);
    for (k = 0; k < 200; k++) begin
      @(negedge CLOCK);
      if (brkrq && !brkwrite && brkaddr == 15'o07755) break;
    end
    abort_ok = 1;
    #1 BINIT = 1'b1;
    @(negedge CLOCK);
    #1 BINIT = 1'b0;
    chk_reset_state("binit");
    flush();
    @(negedge CLOCK);
    abort_ok = 0;
    xfer(1'b1, 12'o2525, 3'd1, 0, 2);

    start_x(1'b0, 12'o0, 3'd5, 6, 6, c0, tot);
    for (k = 0; k < 400; k++) begin
      @(negedge CLOCK);
      if (brkrq && brkaddr == {3'd5, m_ca}) break;
    end
    abort_ok = 1;
    #2 RESET = 1'b1;
    #1;
    chk_reset_state("areset");
    @(negedge CLOCK);
    RESET = 1'b0;
    flush();
    @(negedge CLOCK);
    abort_ok = 0;

    for (int n = 0; n < 25; n++) begin
      logic [2:0] f;
      f = 3'($urandom_range(7, 1));
      mem[15'o07754] = ($urandom_range(3) == 0) ? 12'o7777
                                                : 12'($urandom);
      mem[15'o07755] = ($urandom_range(3) == 0) ? 12'o7777
                                                : 12'($urandom);
      xfer(1'($urandom), 12'($urandom), f, 0, 3);
    end

    repeat (3) @(negedge CLOCK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
